// File: rtl/rs_multi_cdb_if.sv
// Dispatcher / ALU / CDB bundle for the multi-CDB reservation station.
// The slave modport is the reservation station; master is the surrounding core.
interface rs_multi_cdb_if #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 6,
    parameter int NUM_CDB = 2
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        rdy_in;
    logic                        rob_flush_in;
    logic                        dispatch_en_in;
    logic [DATA_W-1:0]           dispatch_vj_in;
    logic [DATA_W-1:0]           dispatch_vk_in;
    logic [ROB_W-1:0]            dispatch_qj_in;
    logic [ROB_W-1:0]            dispatch_qk_in;
    logic                        dispatch_need_j_in;
    logic                        dispatch_need_k_in;
    logic [TYPE_W-1:0]           dispatch_type_in;
    logic [DATA_W-1:0]           dispatch_A_in;
    logic [ROB_W-1:0]            dispatch_dest_in;
    logic [DATA_W-1:0]           dispatch_pc_in;
    logic                        dispatch_rdy_out;
    logic [CNT_W-1:0]            free_cnt_out;
    logic                        alu_en_out;
    logic                        alu_rdy_in;
    logic [DATA_W-1:0]           alu_vj_out;
    logic [DATA_W-1:0]           alu_vk_out;
    logic [DATA_W-1:0]           alu_A_out;
    logic [DATA_W-1:0]           alu_pc_out;
    logic [ROB_W-1:0]            alu_dest_out;
    logic [TYPE_W-1:0]           alu_type_out;
    logic [NUM_CDB-1:0]          cdb_en_in;
    logic [NUM_CDB*ROB_W-1:0]    cdb_tag_in;
    logic [NUM_CDB*DATA_W-1:0]   cdb_val_in;

    modport master (
        output rdy_in, rob_flush_in, dispatch_en_in, dispatch_vj_in, dispatch_vk_in,
               dispatch_qj_in, dispatch_qk_in, dispatch_need_j_in, dispatch_need_k_in,
               dispatch_type_in, dispatch_A_in, dispatch_dest_in, dispatch_pc_in,
               alu_rdy_in, cdb_en_in, cdb_tag_in, cdb_val_in,
        input  dispatch_rdy_out, free_cnt_out, alu_en_out, alu_vj_out, alu_vk_out,
               alu_A_out, alu_pc_out, alu_dest_out, alu_type_out
    );

    modport slave (
        input  rdy_in, rob_flush_in, dispatch_en_in, dispatch_vj_in, dispatch_vk_in,
               dispatch_qj_in, dispatch_qk_in, dispatch_need_j_in, dispatch_need_k_in,
               dispatch_type_in, dispatch_A_in, dispatch_dest_in, dispatch_pc_in,
               alu_rdy_in, cdb_en_in, cdb_tag_in, cdb_val_in,
        output dispatch_rdy_out, free_cnt_out, alu_en_out, alu_vj_out, alu_vk_out,
               alu_A_out, alu_pc_out, alu_dest_out, alu_type_out
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// Reservation station for the integer/branch path: N-channel CDB wakeup,
// oldest-ready-first issue through a registered, back-pressured ALU stage.
module rs_multi_cdb #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 6,
    parameter int NUM_CDB = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    rs_multi_cdb_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Lowest-numbered channel wins when several broadcast the same tag; tag 0 never hits.
    function automatic logic cdb_hit(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*ROB_W-1:0]  tags
    );
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < NUM_CDB; c++) begin
            hit = hit | (en[c] && (tag != '0) && (tags[c*ROB_W +: ROB_W] == tag));
        end
        return hit;
    endfunction

    function automatic logic [DATA_W-1:0] cdb_value(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*ROB_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W-1:0] val;
        val = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (en[c] && (tag != '0) && (tags[c*ROB_W +: ROB_W] == tag)) begin
                val = vals[c*DATA_W +: DATA_W];
            end else begin
                val = val;
            end
        end
        return val;
    endfunction

    logic [DEPTH-1:0]   busy_r;
    logic [DATA_W-1:0]  vj_r   [DEPTH];
    logic [DATA_W-1:0]  vk_r   [DEPTH];
    logic [ROB_W-1:0]   qj_r   [DEPTH];
    logic [ROB_W-1:0]   qk_r   [DEPTH];
    logic [TYPE_W-1:0]  type_r [DEPTH];
    logic [DATA_W-1:0]  a_r    [DEPTH];
    logic [ROB_W-1:0]   dest_r [DEPTH];
    logic [DATA_W-1:0]  pc_r   [DEPTH];
    // older_r[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]   older_r [DEPTH];
    logic [CNT_W-1:0]   free_cnt_r;

    logic               alu_en_r;
    logic [DATA_W-1:0]  alu_vj_r;
    logic [DATA_W-1:0]  alu_vk_r;
    logic [DATA_W-1:0]  alu_a_r;
    logic [DATA_W-1:0]  alu_pc_r;
    logic [ROB_W-1:0]   alu_dest_r;
    logic [TYPE_W-1:0]  alu_type_r;

    logic [DEPTH-1:0]   ready_s;
    logic [DEPTH-1:0]   oldest_s;
    logic               blocked_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               any_rdy_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               disp_acc_s;
    logic               can_issue_s;
    logic               issue_s;
    logic               disp_j_hit_s;
    logic               disp_k_hit_s;
    logic [ROB_W-1:0]   disp_qj_s;
    logic [ROB_W-1:0]   disp_qk_s;
    logic [DATA_W-1:0]  disp_vj_s;
    logic [DATA_W-1:0]  disp_vk_s;

    // Readiness, oldest-ready selection and lowest idle slot, all from registered state.
    always_comb begin
        ready_s   = '0;
        oldest_s  = '0;
        blocked_s = 1'b0;
        sel_idx_s = '0;
        any_rdy_s = 1'b0;
        wr_idx_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = busy_r[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            blocked_s = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s = blocked_s | (ready_s[j] & older_r[j][i]);
            end
            oldest_s[i] = ready_s[i] & ~blocked_s;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (oldest_s[i]) begin
                sel_idx_s = IDX_W'(i);
                any_rdy_s = 1'b1;
            end else begin
                sel_idx_s = sel_idx_s;
            end
            if (!busy_r[i]) begin
                wr_idx_s = IDX_W'(i);
            end else begin
                wr_idx_s = wr_idx_s;
            end
        end
    end

    assign disp_acc_s   = bus.dispatch_en_in && (free_cnt_r != '0);
    assign can_issue_s  = !alu_en_r || bus.alu_rdy_in;
    assign issue_s      = can_issue_s && any_rdy_s;

    assign disp_j_hit_s = cdb_hit(bus.dispatch_qj_in, bus.cdb_en_in, bus.cdb_tag_in);
    assign disp_k_hit_s = cdb_hit(bus.dispatch_qk_in, bus.cdb_en_in, bus.cdb_tag_in);
    assign disp_qj_s    = (!bus.dispatch_need_j_in || disp_j_hit_s) ? '0 : bus.dispatch_qj_in;
    assign disp_qk_s    = (!bus.dispatch_need_k_in || disp_k_hit_s) ? '0 : bus.dispatch_qk_in;
    assign disp_vj_s    = (bus.dispatch_need_j_in && disp_j_hit_s) ?
                          cdb_value(bus.dispatch_qj_in, bus.cdb_en_in, bus.cdb_tag_in, bus.cdb_val_in) :
                          bus.dispatch_vj_in;
    assign disp_vk_s    = (bus.dispatch_need_k_in && disp_k_hit_s) ?
                          cdb_value(bus.dispatch_qk_in, bus.cdb_en_in, bus.cdb_tag_in, bus.cdb_val_in) :
                          bus.dispatch_vk_in;

    // Entry array, age matrix, free count and the registered issue stage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_r     <= '0;
            free_cnt_r <= CNT_W'(DEPTH);
            alu_en_r   <= 1'b0;
            alu_vj_r   <= '0;
            alu_vk_r   <= '0;
            alu_a_r    <= '0;
            alu_pc_r   <= '0;
            alu_dest_r <= '0;
            alu_type_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vj_r[i]    <= '0;
                vk_r[i]    <= '0;
                qj_r[i]    <= '0;
                qk_r[i]    <= '0;
                type_r[i]  <= '0;
                a_r[i]     <= '0;
                dest_r[i]  <= '0;
                pc_r[i]    <= '0;
                older_r[i] <= '0;
            end
        end else if (!bus.rdy_in) begin
            busy_r <= busy_r;
        end else if (bus.rob_flush_in) begin
            busy_r     <= '0;
            free_cnt_r <= CNT_W'(DEPTH);
            alu_en_r   <= 1'b0;
            alu_vj_r   <= '0;
            alu_vk_r   <= '0;
            alu_a_r    <= '0;
            alu_pc_r   <= '0;
            alu_dest_r <= '0;
            alu_type_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            // Wakeup lands in state now; readiness sees it from the next cycle.
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_r[i] && cdb_hit(qj_r[i], bus.cdb_en_in, bus.cdb_tag_in)) begin
                    qj_r[i] <= '0;
                    vj_r[i] <= cdb_value(qj_r[i], bus.cdb_en_in, bus.cdb_tag_in, bus.cdb_val_in);
                end
                if (busy_r[i] && cdb_hit(qk_r[i], bus.cdb_en_in, bus.cdb_tag_in)) begin
                    qk_r[i] <= '0;
                    vk_r[i] <= cdb_value(qk_r[i], bus.cdb_en_in, bus.cdb_tag_in, bus.cdb_val_in);
                end
            end
            if (can_issue_s) begin
                if (any_rdy_s) begin
                    alu_en_r          <= 1'b1;
                    alu_vj_r          <= vj_r[sel_idx_s];
                    alu_vk_r          <= vk_r[sel_idx_s];
                    alu_a_r           <= a_r[sel_idx_s];
                    alu_pc_r          <= pc_r[sel_idx_s];
                    alu_dest_r        <= dest_r[sel_idx_s];
                    alu_type_r        <= type_r[sel_idx_s];
                    busy_r[sel_idx_s] <= 1'b0;
                end else begin
                    alu_en_r <= 1'b0;
                end
            end
            // The write slot is idle in registered state, so it never collides with the issuing entry.
            if (disp_acc_s) begin
                busy_r[wr_idx_s] <= 1'b1;
                vj_r[wr_idx_s]   <= disp_vj_s;
                vk_r[wr_idx_s]   <= disp_vk_s;
                qj_r[wr_idx_s]   <= disp_qj_s;
                qk_r[wr_idx_s]   <= disp_qk_s;
                type_r[wr_idx_s] <= bus.dispatch_type_in;
                a_r[wr_idx_s]    <= bus.dispatch_A_in;
                dest_r[wr_idx_s] <= bus.dispatch_dest_in;
                pc_r[wr_idx_s]   <= bus.dispatch_pc_in;
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[j][wr_idx_s] <= (j != int'(wr_idx_s));
                end
                older_r[wr_idx_s] <= '0;
            end
            free_cnt_r <= free_cnt_r - CNT_W'(disp_acc_s) + CNT_W'(issue_s);
        end
    end

    assign bus.dispatch_rdy_out = (free_cnt_r >= CNT_W'(2));
    assign bus.free_cnt_out     = free_cnt_r;
    assign bus.alu_en_out       = alu_en_r;
    assign bus.alu_vj_out       = alu_vj_r;
    assign bus.alu_vk_out       = alu_vk_r;
    assign bus.alu_A_out        = alu_a_r;
    assign bus.alu_pc_out       = alu_pc_r;
    assign bus.alu_dest_out     = alu_dest_r;
    assign bus.alu_type_out     = alu_type_r;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb: issue order, CDB capture/wakeup,
// back-pressure, full/flush and asynchronous reset.
module tb_rs_multi_cdb;
    localparam int DEPTH   = 16;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 4;
    localparam int TYPE_W  = 6;
    localparam int NUM_CDB = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   errors = 0;

    rs_multi_cdb_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W),
                      .TYPE_W(TYPE_W), .NUM_CDB(NUM_CDB)) bus ();

    rs_multi_cdb #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W),
                   .TYPE_W(TYPE_W), .NUM_CDB(NUM_CDB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [3:0] qj, input logic [3:0] qk, input logic nj, input logic nk,
                        input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
        bus.dispatch_en_in     = 1'b1;
        bus.dispatch_qj_in     = qj;
        bus.dispatch_qk_in     = qk;
        bus.dispatch_need_j_in = nj;
        bus.dispatch_need_k_in = nk;
        bus.dispatch_vj_in     = vj;
        bus.dispatch_vk_in     = vk;
        bus.dispatch_dest_in   = dest;
        bus.dispatch_type_in   = {2'b00, dest};
        bus.dispatch_A_in      = 32'h0000_0100 + {28'd0, dest};
        bus.dispatch_pc_in     = 32'h0000_4000 + {28'd0, dest};
        step();
        bus.dispatch_en_in     = 1'b0;
    endtask

    initial begin
        rst_in                 = 1'b1;
        bus.rdy_in             = 1'b1;
        bus.rob_flush_in       = 1'b0;
        bus.dispatch_en_in     = 1'b0;
        bus.dispatch_vj_in     = 32'd0;
        bus.dispatch_vk_in     = 32'd0;
        bus.dispatch_qj_in     = 4'd0;
        bus.dispatch_qk_in     = 4'd0;
        bus.dispatch_need_j_in = 1'b0;
        bus.dispatch_need_k_in = 1'b0;
        bus.dispatch_type_in   = 6'd0;
        bus.dispatch_A_in      = 32'd0;
        bus.dispatch_dest_in   = 4'd0;
        bus.dispatch_pc_in     = 32'd0;
        bus.alu_rdy_in         = 1'b1;
        bus.cdb_en_in          = 2'b00;
        bus.cdb_tag_in         = 8'd0;
        bus.cdb_val_in         = 64'd0;
        #12;
        check_val("rst_free", bus.free_cnt_out, 64'd16);
        check_val("rst_drdy", bus.dispatch_rdy_out, 64'd1);
        check_val("rst_en", bus.alu_en_out, 64'd0);
        check_val("rst_dest", bus.alu_dest_out, 64'd0);
        rst_in = 1'b0;

        // single ready entry issues one edge after dispatch
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'h11, 32'h22, 4'd5);
        check_val("t1_free_after_disp", bus.free_cnt_out, 64'd15);
        check_val("t1_en_not_yet", bus.alu_en_out, 64'd0);
        step();
        check_val("t1_en", bus.alu_en_out, 64'd1);
        check_val("t1_dest", bus.alu_dest_out, 64'd5);
        check_val("t1_vj", bus.alu_vj_out, 64'h11);
        check_val("t1_vk", bus.alu_vk_out, 64'h22);
        check_val("t1_A", bus.alu_A_out, 64'h105);
        check_val("t1_pc", bus.alu_pc_out, 64'h4005);
        check_val("t1_type", bus.alu_type_out, 64'd5);
        check_val("t1_free", bus.free_cnt_out, 64'd16);
        step();
        check_val("t1_en_drop", bus.alu_en_out, 64'd0);

        // oldest-ready-first: A waits on tag 3, B and C go first
        disp(4'd3, 4'd0, 1'b1, 1'b1, 32'hA0, 32'h0, 4'd1);
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'hB0, 32'h0, 4'd2);
        check_val("t2_free_ab", bus.free_cnt_out, 64'd14);
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'hC0, 32'h0, 4'd3);
        check_val("t2_b_en", bus.alu_en_out, 64'd1);
        check_val("t2_b_dest", bus.alu_dest_out, 64'd2);
        check_val("t2_free_abc", bus.free_cnt_out, 64'd14);
        step();
        check_val("t2_c_dest", bus.alu_dest_out, 64'd3);
        check_val("t2_free_c", bus.free_cnt_out, 64'd15);
        bus.cdb_en_in  = 2'b01;
        bus.cdb_tag_in = {4'd0, 4'd3};
        bus.cdb_val_in = {32'd0, 32'h1234};
        step();
        bus.cdb_en_in  = 2'b00;
        check_val("t2_wake_not_yet", bus.alu_en_out, 64'd0);
        step();
        check_val("t2_a_en", bus.alu_en_out, 64'd1);
        check_val("t2_a_dest", bus.alu_dest_out, 64'd1);
        check_val("t2_a_vj", bus.alu_vj_out, 64'h1234);
        check_val("t2_free_a", bus.free_cnt_out, 64'd16);

        // dispatch-cycle capture from both channels
        bus.cdb_en_in  = 2'b11;
        bus.cdb_tag_in = {4'd7, 4'd2};
        bus.cdb_val_in = {32'hBB, 32'hAA};
        disp(4'd2, 4'd7, 1'b1, 1'b1, 32'h55, 32'h55, 4'd6);
        bus.cdb_en_in  = 2'b00;
        step();
        check_val("t3_cap_en", bus.alu_en_out, 64'd1);
        check_val("t3_cap_dest", bus.alu_dest_out, 64'd6);
        check_val("t3_cap_vj", bus.alu_vj_out, 64'hAA);
        check_val("t3_cap_vk", bus.alu_vk_out, 64'hBB);
        disp(4'd0, 4'd9, 1'b1, 1'b0, 32'h1, 32'h99, 4'd7);
        step();
        check_val("t3_needk_en", bus.alu_en_out, 64'd1);
        check_val("t3_needk_dest", bus.alu_dest_out, 64'd7);
        check_val("t3_needk_vk", bus.alu_vk_out, 64'h99);
        // same tag on both channels: channel 0 value wins
        disp(4'd6, 4'd0, 1'b1, 1'b1, 32'h0, 32'h0, 4'd8);
        bus.cdb_en_in  = 2'b11;
        bus.cdb_tag_in = {4'd6, 4'd6};
        bus.cdb_val_in = {32'h601, 32'h600};
        step();
        bus.cdb_en_in  = 2'b00;
        step();
        check_val("t3_prio_dest", bus.alu_dest_out, 64'd8);
        check_val("t3_prio_vj", bus.alu_vj_out, 64'h600);

        // back-pressure with a waiting entry W parked on tag 12
        disp(4'd12, 4'd0, 1'b1, 1'b1, 32'h0, 32'h0, 4'd9);
        bus.alu_rdy_in = 1'b0;
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'h10A, 32'h0, 4'd10);
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'h10B, 32'h0, 4'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t4_hold_en", bus.alu_en_out, 64'd1);
            check_val("t4_hold_dest", bus.alu_dest_out, 64'd10);
            check_val("t4_hold_vj", bus.alu_vj_out, 64'h10A);
            check_val("t4_hold_free", bus.free_cnt_out, 64'd14);
        end
        bus.alu_rdy_in = 1'b1;
        step();
        check_val("t4_next_dest", bus.alu_dest_out, 64'd11);
        check_val("t4_next_free", bus.free_cnt_out, 64'd15);
        bus.cdb_en_in  = 2'b10;
        bus.cdb_tag_in = {4'd12, 4'd0};
        bus.cdb_val_in = {32'hC, 32'h0};
        step();
        bus.cdb_en_in  = 2'b00;
        step();
        check_val("t4_w_dest", bus.alu_dest_out, 64'd9);
        check_val("t4_w_vj", bus.alu_vj_out, 64'hC);
        check_val("t4_w_free", bus.free_cnt_out, 64'd16);
        step();

        // fill all entries waiting on tag 4
        for (int i = 0; i < 16; i++) begin
            check_val("t5_fill_free", bus.free_cnt_out, 64'(16 - i));
            check_val("t5_fill_drdy", bus.dispatch_rdy_out, (16 - i >= 2) ? 64'd1 : 64'd0);
            disp(4'd4, 4'd0, 1'b1, 1'b1, 32'(i), 32'h0, 4'(i));
        end
        check_val("t5_full_free", bus.free_cnt_out, 64'd0);
        check_val("t5_full_drdy", bus.dispatch_rdy_out, 64'd0);
        check_val("t5_full_en", bus.alu_en_out, 64'd0);
        // flush wins over a same-cycle dispatch
        bus.rob_flush_in   = 1'b1;
        bus.dispatch_en_in = 1'b1;
        bus.dispatch_qj_in = 4'd0;
        bus.dispatch_qk_in = 4'd0;
        step();
        bus.rob_flush_in   = 1'b0;
        bus.dispatch_en_in = 1'b0;
        check_val("t5_flush_free", bus.free_cnt_out, 64'd16);
        check_val("t5_flush_en", bus.alu_en_out, 64'd0);
        check_val("t5_flush_drdy", bus.dispatch_rdy_out, 64'd1);
        bus.cdb_en_in  = 2'b01;
        bus.cdb_tag_in = {4'd0, 4'd4};
        bus.cdb_val_in = {32'd0, 32'h44};
        step();
        bus.cdb_en_in  = 2'b00;
        step();
        check_val("t5_post_flush_en", bus.alu_en_out, 64'd0);
        step();
        check_val("t5_post_flush_en2", bus.alu_en_out, 64'd0);
        check_val("t5_post_flush_free", bus.free_cnt_out, 64'd16);

        // asynchronous reset while an issue is stalled
        bus.alu_rdy_in = 1'b0;
        disp(4'd15, 4'd0, 1'b1, 1'b1, 32'h0, 32'h0, 4'd14);
        disp(4'd0, 4'd0, 1'b1, 1'b1, 32'hD0, 32'h0, 4'd13);
        step();
        check_val("t6_stall_en", bus.alu_en_out, 64'd1);
        check_val("t6_stall_dest", bus.alu_dest_out, 64'd13);
        check_val("t6_stall_free", bus.free_cnt_out, 64'd15);
        #3;
        rst_in = 1'b1;
        #1;
        check_val("t6_arst_en", bus.alu_en_out, 64'd0);
        check_val("t6_arst_free", bus.free_cnt_out, 64'd16);
        check_val("t6_arst_dest", bus.alu_dest_out, 64'd0);
        #2;
        rst_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
